// File: rtl/flag_branch_unit.sv
// rtl/flag_branch_unit.sv - comparator flag latch, conditional branch resolution and PC owner
// Define BR_STATS_EN to add saturating taken_cnt / wait_cnt statistics outputs.
`timescale 1ns/1ps
module flag_branch_unit #(
  parameter int ADDR_W       = 10,
  parameter int RESET_PC     = 0,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              ZF,
  input  logic              CF,
  input  logic              flag_valid,
  input  logic              br_valid,
  input  logic [2:0]        br_op,
  input  logic [ADDR_W-1:0] br_target,
  output logic              br_ready,
  input  logic              pc_en,
  output logic [ADDR_W-1:0] pc_out,
  output logic              br_taken,
  output logic              flush,
  output logic [1:0]        flags_out
`ifdef BR_STATS_EN
  ,
  output logic [15:0]       taken_cnt,
  output logic [15:0]       wait_cnt
`endif
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_WAIT  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  localparam logic [2:0] OP_JMP = 3'b000;
  localparam logic [2:0] OP_NOP = 3'b111;

  // The counter is loaded with one less than the window so it reaches zero in the last flush cycle.
  localparam logic [3:0] FLUSH_LOAD = (FLUSH_CYCLES > 0) ? 4'(FLUSH_CYCLES - 1) : 4'd0;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_pc;
  logic                r_zf;
  logic                r_cf;
  logic                r_fv;
  logic [2:0]          r_op;
  logic [ADDR_W-1:0]   r_target;
  logic                r_taken;
  logic [3:0]          r_flush_cnt;

  logic                w_eff_zf;
  logic                w_eff_cf;
  logic                w_accept;
  logic                w_resolve;
  logic                w_defer;
  logic                w_take;
  logic [2:0]          w_op;
  logic [ADDR_W-1:0]   w_tgt;

  function automatic logic cond_met(input logic [2:0] op, input logic zf, input logic cf);
    case (op)
      3'b000:  cond_met = 1'b1;
      3'b001:  cond_met = zf;
      3'b010:  cond_met = !zf;
      3'b011:  cond_met = cf;
      3'b100:  cond_met = !cf;
      3'b101:  cond_met = !cf && !zf;
      3'b110:  cond_met = cf || zf;
      default: cond_met = 1'b0;
    endcase
  endfunction

  // Incoming flags bypass the latch so a compare and a branch may land in the same cycle.
  always_comb begin
    w_eff_zf  = flag_valid ? ZF : r_zf;
    w_eff_cf  = flag_valid ? CF : r_cf;
    w_accept  = br_valid && (r_state == S_RUN);
    w_resolve = 1'b0;
    w_defer   = 1'b0;
    w_op      = br_op;
    w_tgt     = br_target;
    case (r_state)
      S_RUN: begin
        if (w_accept) begin
          if ((br_op == OP_JMP) || (br_op == OP_NOP) || r_fv || flag_valid) begin
            w_resolve = 1'b1;
          end else begin
            w_defer = 1'b1;
          end
        end
      end
      S_WAIT: begin
        w_op      = r_op;
        w_tgt     = r_target;
        w_resolve = flag_valid;
      end
      default: ;
    endcase
    w_take = w_resolve && cond_met(w_op, w_eff_zf, w_eff_cf);
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN: begin
        if (w_take && (FLUSH_CYCLES != 0)) begin
          w_state_nxt = S_FLUSH;
        end else if (w_defer) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_take && (FLUSH_CYCLES != 0)) begin
          w_state_nxt = S_FLUSH;
        end else if (w_resolve) begin
          w_state_nxt = S_RUN;
        end
      end
      S_FLUSH: begin
        if (r_flush_cnt == 4'd0) begin
          w_state_nxt = S_RUN;
        end
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_comb begin
    br_ready = (r_state == S_RUN);
    flush    = (r_state == S_FLUSH);
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_pc        <= ADDR_W'(RESET_PC);
      r_zf        <= 1'b0;
      r_cf        <= 1'b0;
      r_fv        <= 1'b0;
      r_op        <= 3'b000;
      r_target    <= '0;
      r_taken     <= 1'b0;
      r_flush_cnt <= 4'd0;
    end else begin
      r_taken <= w_take;
      if (flag_valid) begin
        r_zf <= ZF;
        r_cf <= CF;
        r_fv <= 1'b1;
      end
      if (w_defer) begin
        r_op     <= br_op;
        r_target <= br_target;
      end
      // An accepted branch wins over pc_en; WAIT and FLUSH ignore pc_en entirely.
      if (w_take) begin
        r_pc <= w_tgt;
      end else if (w_resolve) begin
        r_pc <= r_pc + ADDR_W'(1);
      end else if ((r_state == S_RUN) && !w_accept && pc_en) begin
        r_pc <= r_pc + ADDR_W'(1);
      end
      if (w_take) begin
        r_flush_cnt <= FLUSH_LOAD;
      end else if ((r_state == S_FLUSH) && (r_flush_cnt != 4'd0)) begin
        r_flush_cnt <= r_flush_cnt - 4'd1;
      end
    end
  end

  assign pc_out    = r_pc;
  assign br_taken  = r_taken;
  assign flags_out = {r_cf, r_zf};

`ifdef BR_STATS_EN
  logic [15:0] r_taken_cnt;
  logic [15:0] r_wait_cnt;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_taken_cnt <= 16'd0;
      r_wait_cnt  <= 16'd0;
    end else begin
      if (w_take && (r_taken_cnt != 16'hFFFF)) begin
        r_taken_cnt <= r_taken_cnt + 16'd1;
      end
      if ((r_state == S_WAIT) && (r_wait_cnt != 16'hFFFF)) begin
        r_wait_cnt <= r_wait_cnt + 16'd1;
      end
    end
  end

  assign taken_cnt = r_taken_cnt;
  assign wait_cnt  = r_wait_cnt;
`endif

endmodule

// File: tb/tb_flag_branch_unit.sv
// tb/tb_flag_branch_unit.sv - directed and randomized checks of flag_branch_unit against a reference model
`timescale 1ns/1ps
module tb_flag_branch_unit;
  localparam int ADDR_W       = 10;
  localparam int FLUSH_CYCLES = 2;

  logic              clk = 1'b0;
  logic              clear;
  logic              zf, cf, flag_valid, br_valid, pc_en;
  logic [2:0]        br_op;
  logic [ADDR_W-1:0] br_target;
  logic              br_ready, br_taken, flush;
  logic [ADDR_W-1:0] pc_out;
  logic [1:0]        flags_out;
`ifdef BR_STATS_EN
  logic [15:0]       taken_cnt, wait_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  flag_branch_unit #(.ADDR_W(ADDR_W), .RESET_PC(0), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk(clk), .clear(clear), .ZF(zf), .CF(cf), .flag_valid(flag_valid),
    .br_valid(br_valid), .br_op(br_op), .br_target(br_target), .br_ready(br_ready),
    .pc_en(pc_en), .pc_out(pc_out), .br_taken(br_taken), .flush(flush), .flags_out(flags_out)
`ifdef BR_STATS_EN
    , .taken_cnt(taken_cnt), .wait_cnt(wait_cnt)
`endif
  );

  // Reference model: architectural PC, flags, a parked branch and a remaining-flush count.
  logic [ADDR_W-1:0] m_pc, m_ptgt;
  logic [2:0]        m_pop;
  bit                m_zf, m_cf, m_fv, m_pend, m_taken;
  int                m_flush_left;

  function automatic bit rule_taken(input logic [2:0] op, input bit z, input bit c);
    case (op)
      3'd0: return 1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return c;
      3'd4: return !c;
      3'd5: return !c && !z;
      3'd6: return c || z;
      default: return 0;
    endcase
  endfunction

  function automatic bit model_ready();
    return !m_pend && (m_flush_left == 0);
  endfunction

  task automatic model_reset();
    m_pc = '0; m_ptgt = '0; m_pop = 3'd0;
    m_zf = 0; m_cf = 0; m_fv = 0; m_pend = 0; m_taken = 0; m_flush_left = 0;
  endtask

  task automatic model_resolve(input logic [2:0] op, input logic [ADDR_W-1:0] tgt,
                               input bit z, input bit c, output bit taken);
    taken = rule_taken(op, z, c);
    if (taken) begin
      m_pc = tgt;
      m_flush_left = FLUSH_CYCLES;
    end else begin
      m_pc = m_pc + 1'b1;
    end
    m_pend = 0;
  endtask

  task automatic model_step();
    bit ez, ec, nt;
    ez = flag_valid ? zf : m_zf;
    ec = flag_valid ? cf : m_cf;
    nt = 0;
    if (m_flush_left > 0) begin
      m_flush_left--;
    end else if (m_pend) begin
      if (flag_valid) model_resolve(m_pop, m_ptgt, zf, cf, nt);
    end else if (br_valid) begin
      if (br_op == 3'd0 || br_op == 3'd7 || m_fv || flag_valid) begin
        model_resolve(br_op, br_target, ez, ec, nt);
      end else begin
        m_pend = 1; m_pop = br_op; m_ptgt = br_target;
      end
    end else if (pc_en) begin
      m_pc = m_pc + 1'b1;
    end
    m_taken = nt;
    if (flag_valid) begin
      m_zf = zf; m_cf = cf; m_fv = 1;
    end
  endtask

  task automatic idle_inputs();
    zf = 0; cf = 0; flag_valid = 0; br_valid = 0; br_op = 3'd0; br_target = '0; pc_en = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    clear = 0;
    tick();
    clear = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    clear = 0;
    #12;
    checks++; if (pc_out !== 10'h000) begin errors++; $display("FAIL reset_pc got %h exp 000", pc_out); end
    checks++; if (flags_out !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", flags_out); end
    checks++; if (br_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", br_ready); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %b exp 0", flush); end
    checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL reset_taken got %b exp 0", br_taken); end
    tick();
    clear = 1;
  endtask

  task automatic test_sequential();
    do_reset();
    pc_en = 1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++; if (pc_out !== ADDR_W'(i)) begin errors++; $display("FAIL seq_pc got %h exp %h", pc_out, ADDR_W'(i)); end
      checks++; if (br_ready !== 1'b1 || flush !== 1'b0) begin errors++; $display("FAIL seq_ready_flush got %b%b exp 10", br_ready, flush); end
    end
    pc_en = 0;
  endtask

  task automatic test_je_taken();
    do_reset();
    flag_valid = 1; zf = 1; cf = 0;
    tick();
    flag_valid = 0;
    checks++; if (flags_out !== 2'b01) begin errors++; $display("FAIL je_flags got %b exp 01", flags_out); end
    br_valid = 1; br_op = 3'd1; br_target = 10'h3A0; pc_en = 1;
    tick();
    br_valid = 0;
    checks++; if (pc_out !== 10'h3A0) begin errors++; $display("FAIL je_pc got %h exp 3a0", pc_out); end
    checks++; if (br_taken !== 1'b1) begin errors++; $display("FAIL je_taken got %b exp 1", br_taken); end
    checks++; if (flush !== 1'b1 || br_ready !== 1'b0) begin errors++; $display("FAIL je_flush1 got %b%b exp 10", flush, br_ready); end
    tick();
    checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL je_pulse got %b exp 0", br_taken); end
    checks++; if (flush !== 1'b1 || br_ready !== 1'b0) begin errors++; $display("FAIL je_flush2 got %b%b exp 10", flush, br_ready); end
    checks++; if (pc_out !== 10'h3A0) begin errors++; $display("FAIL je_hold got %h exp 3a0", pc_out); end
    tick();
    checks++; if (flush !== 1'b0 || br_ready !== 1'b1) begin errors++; $display("FAIL je_flush_end got %b%b exp 01", flush, br_ready); end
    pc_en = 0;
  endtask

  task automatic test_ja_not_taken();
    do_reset();
    pc_en = 1;
    repeat (7) tick();
    pc_en = 0;
    flag_valid = 1; zf = 0; cf = 1;
    tick();
    flag_valid = 0;
    br_valid = 1; br_op = 3'd5; br_target = 10'h100;
    tick();
    br_valid = 0;
    checks++; if (pc_out !== 10'h008) begin errors++; $display("FAIL ja_pc got %h exp 008", pc_out); end
    checks++; if (br_taken !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL ja_taken_flush got %b%b exp 00", br_taken, flush); end
    checks++; if (flags_out !== 2'b10) begin errors++; $display("FAIL ja_flags got %b exp 10", flags_out); end
  endtask

  task automatic test_wait_flag();
    do_reset();
    br_valid = 1; br_op = 3'd2; br_target = 10'h055; pc_en = 1;
    tick();
    br_valid = 0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (pc_out !== 10'h000 || br_ready !== 1'b0) begin errors++; $display("FAIL wait_hold got pc %h rdy %b exp 000 0", pc_out, br_ready); end
      tick();
    end
    flag_valid = 1; zf = 0; cf = 0;
    tick();
    flag_valid = 0; pc_en = 0;
    checks++; if (pc_out !== 10'h055) begin errors++; $display("FAIL wait_pc got %h exp 055", pc_out); end
    checks++; if (br_taken !== 1'b1) begin errors++; $display("FAIL wait_taken got %b exp 1", br_taken); end
    tick();
    checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL wait_pulse got %b exp 0", br_taken); end
  endtask

  task automatic test_wrap_and_async_clear();
    do_reset();
    br_valid = 1; br_op = 3'd0; br_target = 10'h3FF;
    tick();
    br_valid = 0;
    checks++; if (pc_out !== 10'h3FF) begin errors++; $display("FAIL wrap_jmp got %h exp 3ff", pc_out); end
    tick(); tick();
    pc_en = 1;
    tick();
    pc_en = 0;
    checks++; if (pc_out !== 10'h000) begin errors++; $display("FAIL wrap_pc got %h exp 000", pc_out); end
    flag_valid = 1; zf = 1; cf = 1;
    tick();
    flag_valid = 0;
    br_valid = 1; br_op = 3'd0; br_target = 10'h123;
    tick();
    br_valid = 0;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL mid_flush_setup got %b exp 1", flush); end
    #3 clear = 0;
    #1;
    checks++; if (pc_out !== 10'h000) begin errors++; $display("FAIL async_pc got %h exp 000", pc_out); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL async_flush got %b exp 0", flush); end
    checks++; if (flags_out !== 2'b00) begin errors++; $display("FAIL async_flags got %b exp 00", flags_out); end
    checks++; if (br_ready !== 1'b1) begin errors++; $display("FAIL async_ready got %b exp 1", br_ready); end
    tick();
    clear = 1;
  endtask

  task automatic test_random();
    bit                req_active, accepted;
    logic [2:0]        req_op;
    logic [ADDR_W-1:0] req_tgt;
    req_active = 0; req_op = 3'd0; req_tgt = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 250 == 0) begin
        do_reset();
        model_reset();
        req_active = 0;
      end
      if (!req_active && $urandom_range(0, 2) == 0) begin
        req_active = 1;
        req_op = 3'($urandom_range(0, 7));
        req_tgt = ($urandom_range(0, 3) == 0) ? 10'h3FF : ADDR_W'($urandom);
      end
      br_valid = req_active; br_op = req_op; br_target = req_tgt;
      flag_valid = ($urandom_range(0, 4) == 0);
      zf = 1'($urandom); cf = 1'($urandom); pc_en = 1'($urandom);
      accepted = req_active && model_ready();
      model_step();
      tick();
      if (accepted) req_active = 0;
      checks++; if (pc_out !== m_pc) begin errors++; $display("FAIL rnd_pc cyc %0d got %h exp %h", cyc, pc_out, m_pc); end
      checks++; if (br_taken !== m_taken) begin errors++; $display("FAIL rnd_taken cyc %0d got %b exp %b", cyc, br_taken, m_taken); end
      checks++; if (flush !== (m_flush_left > 0)) begin errors++; $display("FAIL rnd_flush cyc %0d got %b exp %b", cyc, flush, m_flush_left > 0); end
      checks++; if (br_ready !== model_ready()) begin errors++; $display("FAIL rnd_ready cyc %0d got %b exp %b", cyc, br_ready, model_ready()); end
      checks++; if (flags_out !== {m_cf, m_zf}) begin errors++; $display("FAIL rnd_flags cyc %0d got %b exp %b", cyc, flags_out, {m_cf, m_zf}); end
    end
    idle_inputs();
  endtask

`ifdef BR_STATS_EN
  task automatic test_stats();
    do_reset();
    checks++; if (taken_cnt !== 16'd0 || wait_cnt !== 16'd0) begin errors++; $display("FAIL stats_reset got %0d %0d exp 0 0", taken_cnt, wait_cnt); end
    for (int i = 0; i < 3; i++) begin
      br_valid = 1; br_op = 3'd0; br_target = ADDR_W'(16 * i + 4);
      tick();
      br_valid = 0;
      tick(); tick();
    end
    br_valid = 1; br_op = 3'd1; br_target = 10'h200;
    tick();
    br_valid = 0;
    tick(); tick(); tick();
    flag_valid = 1; zf = 0; cf = 0;
    tick();
    flag_valid = 0;
    checks++; if (taken_cnt !== 16'd3) begin errors++; $display("FAIL stats_taken got %0d exp 3", taken_cnt); end
    checks++; if (wait_cnt !== 16'd4) begin errors++; $display("FAIL stats_wait got %0d exp 4", wait_cnt); end
  endtask
`endif

  initial begin
    clear = 0;
    idle_inputs();
    test_reset();
    test_sequential();
    test_je_taken();
    test_ja_not_taken();
    test_wait_flag();
    test_wrap_and_async_clear();
    test_random();
`ifdef BR_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/flag_branch_unit.md
Name: flag_branch_unit

Overview:
- Consumer end of the comparator flag interface. Latches ZF/CF when the comparator signals a valid compare.
- Evaluates conditional-jump requests against the latched flags and owns the program counter (PC).
- Sits between the comparator and instruction fetch: drives the next PC and a fetch-flush on taken branches.

Parameters:
- ADDR_W, 10, PC/target width in bits.
- RESET_PC, 0, PC value loaded on reset.
- FLUSH_CYCLES, 2, cycles that flush stays high after a taken branch; legal range 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- clear  input  1  asynchronous active-low reset.
- ZF  input  1  comparator zero flag (CMP1 == CMP2).
- CF  input  1  comparator carry flag (CMP1 < CMP2, unsigned 18-bit).
- flag_valid  input  1  ZF/CF are valid this cycle; this is the CMPsignal-timed strobe.
- br_valid  input  1  branch request present.
- br_op  input  3  branch opcode.
- br_target  input  ADDR_W  jump target.
- br_ready  output  1  branch can be accepted; high exactly when state == RUN.
- pc_en  input  1  advance PC by one (sequential fetch).
- pc_out  output  ADDR_W  current PC (registered).
- br_taken  output  1  one-cycle pulse on a taken branch.
- flush  output  1  fetch-flush window.
- flags_out  output  2  latched {CF, ZF}.

Behaviour:
- Reset (clear = 0, async):
  - pc_out = RESET_PC; flags_out = 0; internal flags-valid bit fv = 0.
  - br_taken = 0; flush = 0; state = RUN.
  - Any pending branch is discarded, including during WAIT_FLAG or FLUSH.
- Flag register:
  - On flag_valid, {CF, ZF} is latched and fv is set.
  - Flags persist until the next flag_valid or reset; branches do not consume them.
- Opcodes:
  - 000 JMP: always taken.
  - 001 JE: taken if ZF.
  - 010 JNE: taken if !ZF.
  - 011 JB: taken if CF.
  - 100 JAE: taken if !CF.
  - 101 JA: taken if !CF & !ZF.
  - 110 JBE: taken if CF | ZF.
  - 111 NOP: never taken; PC + 1.
- Flag bypass: if flag_valid and the branch evaluation happen in the same cycle, the incoming ZF/CF are used, not the latched values.
- Handshake:
  - A branch is accepted when br_valid & br_ready.
  - The requester holds br_valid, br_op and br_target stable until accepted.
  - An accepted branch takes precedence over pc_en in the same cycle.
- FSM states: RUN, WAIT_FLAG, FLUSH.
- RUN:
  - No accept and pc_en = 1: PC + 1. No accept and pc_en = 0: PC holds.
  - Accept of JMP/NOP, or of a conditional when fv = 1 (or flag_valid is high): evaluate immediately.
    - Taken: pc_out = br_target on the next edge; br_taken pulses one cycle; go to FLUSH, or stay in RUN if FLUSH_CYCLES = 0.
    - Not taken: PC + 1.
  - Accept of a conditional when fv = 0 and flag_valid = 0: latch op and target, go to WAIT_FLAG.
- WAIT_FLAG:
  - br_ready = 0; PC holds; pc_en is ignored.
  - On flag_valid: evaluate with the incoming flags, then resolve as taken or not taken, same as RUN.
- FLUSH:
  - flush = 1 for exactly FLUSH_CYCLES cycles, starting the cycle after the branch is taken; a down-counter tracks this.
  - PC holds; pc_en is ignored; br_ready = 0.
  - flag_valid is still latched.
  - Then return to RUN.
- Arithmetic: PC increments modulo 2^ADDR_W, so (2^ADDR_W) − 1 wraps to 0. A target equal to the current PC is legal.

Optional Feature:
- BR_STATS_EN defined:
  - Adds output taken_cnt (16 bits) and output wait_cnt (16 bits), both reset to 0.
  - taken_cnt increments on each br_taken pulse; wait_cnt increments each cycle spent in WAIT_FLAG.
  - Both saturate at 16'hFFFF.
- BR_STATS_EN undefined: neither port nor the counters exist; all other behaviour is identical.

Test Plan:
- Reset, then pc_en = 1 for 5 cycles -> pc_out goes 0, 1, 2, 3, 4, 5; br_ready = 1; flush = 0.
- flag_valid with ZF = 1, CF = 0, then JE to target 0x3A0 -> next cycle pc_out = 0x3A0; br_taken is high 1 cycle; flush is high 2 cycles; br_ready = 0 for those 2 cycles.
- Latched ZF = 0, CF = 1; JA to 0x100 from PC = 7 -> not taken; pc_out = 8; br_taken = 0; no flush.
- After reset (fv = 0), JNE to 0x055 -> WAIT_FLAG, PC holds 3 cycles with pc_en = 1; then flag_valid with ZF = 0 -> pc_out = 0x055, br_taken pulses.
- PC = 0x3FF, pc_en = 1 -> pc_out = 0x000. Assert clear mid-FLUSH -> pc_out = 0, flush = 0 and flags_out = 0 immediately (async).
- BR_STATS_EN: 3 taken JMPs plus 4 WAIT_FLAG cycles -> taken_cnt = 3, wait_cnt = 4.
